// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory read-modify-write bridge.
package dmem_pkg;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] WBH_WORD = 2'b00;
  localparam logic [1:0] WBH_HALF = 2'b01;
  localparam logic [1:0] WBH_BYTE = 2'b10;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
endpackage

// File: rtl/dmem_lane_unit.sv
// Little-endian lane extract (with sign/zero extension) and lane merge for sub-word accesses.
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        addr_lo,
  input  logic [1:0]        wbh,
  input  logic              wbh_fh,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_val,
  output logic [DATA_W-1:0] store_word
);
  logic [15:0] lane_h;
  logic [7:0]  lane_b;

  always_comb begin
    load_val   = word;
    store_word = wdata;
    lane_h     = addr_lo[1] ? word[31:16] : word[15:0];
    lane_b     = word[{addr_lo, 3'b000} +: 8];
    case (wbh)
      WBH_HALF: begin
        load_val   = {{16{wbh_fh & lane_h[15]}}, lane_h};
        store_word = addr_lo[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]};
      end
      WBH_BYTE: begin
        load_val   = {{24{wbh_fh & lane_b[7]}}, lane_b};
        store_word = word;
        store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/dmem_rmw_bridge.sv
// CPU data-memory responder: word/half/byte loads and stores over a single-port word RAM.
// Optional misaligned-access trap enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_rmw_bridge #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              wena,
  input  logic [1:0]        wbh,
  input  logic              wbh_fh,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic [ADDR_W-3:0] mem_addr,
  output logic              mem_wena,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_MISALIGN_TRAP_EN
  ,
  output logic              misalign
`endif
);
  import dmem_pkg::*;

  if (DATA_W != dmem_pkg::DATA_W) begin : g_data_w_check
    $error("dmem_rmw_bridge: DATA_W must be 32");
  end

  state_t state, state_next;

  logic [1:0]        addr_lo_q;
  logic [1:0]        wbh_q;
  logic              fh_q;
  logic              wena_q;
  logic [DATA_W-1:0] wdata_q;

  logic              is_word_in;
  logic              trap;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] store_word;

  assign is_word_in = (wbh != WBH_HALF) && (wbh != WBH_BYTE);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign trap = ((wbh == WBH_HALF) && addr[0]) || (is_word_in && (addr[1:0] != 2'b00));
`else
  assign trap = 1'b0;
`endif

  dmem_lane_unit u_lane (
    .word       (mem_rdata),
    .addr_lo    (addr_lo_q),
    .wbh        (wbh_q),
    .wbh_fh     (fh_q),
    .wdata      (wdata_q),
    .load_val   (load_val),
    .store_word (store_word)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (trap)                    state_next = RESP;
          else if (wena && is_word_in) state_next = WR;
          else                         state_next = RD;
        end
      end
      RD:      state_next = wena_q ? WR : RESP;
      WR:      state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign ready = (state == RESP);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wena  <= 1'b0;
      mem_wdata <= '0;
      addr_lo_q <= '0;
      wbh_q     <= '0;
      fh_q      <= 1'b0;
      wena_q    <= 1'b0;
      wdata_q   <= '0;
`ifdef DMEM_MISALIGN_TRAP_EN
      misalign  <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      // Write strobe is registered so it covers exactly the WR cycle.
      mem_wena <= (state_next == WR);
      if (state == IDLE && req) begin
        addr_lo_q <= addr[1:0];
        wbh_q     <= wbh;
        fh_q      <= wbh_fh;
        wena_q    <= wena;
        wdata_q   <= wdata;
        if (!trap) mem_addr <= addr[ADDR_W-1:2];
        if (!trap && wena && is_word_in) mem_wdata <= wdata;
      end
      if (state == RD) begin
        if (wena_q) mem_wdata <= store_word;
        else        rdata     <= load_val;
      end
`ifdef DMEM_MISALIGN_TRAP_EN
      misalign <= (state == IDLE) && req && trap;
`endif
    end
  end
endmodule

// File: tb/tb_dmem_rmw_bridge.sv
// Directed bench for dmem_rmw_bridge: word RAM environment, arithmetic reference model, per-cycle compare.
module tb_dmem_rmw_bridge;
  import dmem_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        req;
  logic        wena;
  logic [1:0]  wbh;
  logic        wbh_fh;
  logic [12:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic [10:0] mem_addr;
  logic        mem_wena;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  dmem_rmw_bridge #(.ADDR_W(13), .DATA_W(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .wena      (wena),
    .wbh       (wbh),
    .wbh_fh    (wbh_fh),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .ready     (ready),
    .mem_addr  (mem_addr),
    .mem_wena  (mem_wena),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    .misalign  (misalign)
`endif
  );

  always #5 clock = ~clock;

  // RAM environment: data for the registered mem_addr is available by the end of that cycle.
  logic [31:0] ram [0:2047];
  logic        poke_en = 1'b0;
  logic [10:0] poke_idx = '0;
  logic [31:0] poke_val = '0;
  assign mem_rdata = ram[mem_addr];
  always @(posedge clock) begin
    if (mem_wena) ram[mem_addr] <= mem_wdata;
    if (poke_en)  ram[poke_idx] <= poke_val;
  end

  int cyc = 0;
  logic rst_q = 1'b0;
  always @(posedge clock) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference state
  logic [31:0] ref_mem [0:2047];
  int          acc_cyc   = -1;
  int          exp_ready = -1;
  int          exp_wena  = -1;
  logic [31:0] exp_waddr = '0;
  logic [31:0] exp_wdata = '0;
  logic [31:0] pend_val  = '0;
  bit          pend_load = 1'b0;
  bit          exp_mis   = 1'b0;
  bit          exp_trap  = 1'b0;
  logic [31:0] model_rdata = '0;

  logic [31:0] last_wdata = '0;
  logic [31:0] last_waddr = '0;
  logic [31:0] last_rdata = '0;
  logic [31:0] last_mis   = '0;

  always @(negedge clock) begin
    if (cyc >= 1) begin
      if (rst_q) begin
        model_rdata = '0;
        check("rst_ready", {31'b0, ready}, 32'd0);
        check("rst_mem_wena", {31'b0, mem_wena}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_mem_addr", {21'b0, mem_addr}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("rst_misalign", {31'b0, misalign}, 32'd0);
`endif
      end else begin
        if (cyc == exp_ready && pend_load) model_rdata = pend_val;
        check("ready", {31'b0, ready}, {31'b0, cyc == exp_ready});
        check("mem_wena", {31'b0, mem_wena}, {31'b0, cyc == exp_wena});
        if (cyc == exp_wena) begin
          check("wr_data", mem_wdata, exp_wdata);
          last_wdata = mem_wdata;
          last_waddr = {21'b0, mem_addr};
        end
        if (!exp_trap && cyc > acc_cyc && cyc <= exp_ready)
          check("busy_mem_addr", {21'b0, mem_addr}, exp_waddr);
        check("rdata", rdata, model_rdata);
        if (cyc == exp_ready) last_rdata = rdata;
`ifdef DMEM_MISALIGN_TRAP_EN
        check("misalign", {31'b0, misalign}, {31'b0, (cyc == exp_ready) && exp_mis});
        if (cyc == exp_ready) last_mis = {31'b0, misalign};
`endif
      end
    end
  end

  task automatic poke(input int unsigned idx, input logic [31:0] val);
    poke_en  = 1'b1;
    poke_idx = idx[10:0];
    poke_val = val;
    ref_mem[idx] = val;
    @(posedge clock); #1;
    poke_en = 1'b0;
  endtask

  // Called one ns after a posedge with the DUT idle; returns in the following idle cycle.
  task automatic do_req(input logic we, input logic [1:0] w, input logic fh,
                        input logic [12:0] a, input logic [31:0] d);
    int unsigned wi;
    int unsigned sh;
    logic [31:0] word, mask, v, nw;
    bit is_half, is_byte, trp;
    int lat;
    wi      = int'(a) / 4;
    word    = ref_mem[wi];
    is_half = (w == 2'b01);
    is_byte = (w == 2'b10);
    trp     = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    trp = (is_half && a[0]) || (!is_half && !is_byte && (a % 4 != 0));
`endif
    v  = word;
    nw = d;
    if (is_byte) begin
      sh   = 8 * (int'(a) % 4);
      mask = 32'hFF << sh;
      v    = (word >> sh) & 32'hFF;
      if (fh && v >= 32'h80) v = v | 32'hFFFF_FF00;
      nw   = (word & ~mask) | ((d & 32'hFF) << sh);
    end else if (is_half) begin
      sh   = 16 * ((int'(a) / 2) % 2);
      mask = 32'hFFFF << sh;
      v    = (word >> sh) & 32'hFFFF;
      if (fh && v >= 32'h8000) v = v | 32'hFFFF_0000;
      nw   = (word & ~mask) | ((d & 32'hFFFF) << sh);
    end
    if (trp)                      lat = 1;
    else if (we && (is_half || is_byte)) lat = 3;
    else                          lat = 2;
    acc_cyc   = cyc;
    exp_ready = cyc + lat;
    exp_wena  = (!trp && we) ? cyc + lat - 1 : -1;
    exp_waddr = wi;
    exp_wdata = nw;
    pend_val  = v;
    pend_load = !we && !trp;
    exp_mis   = trp;
    exp_trap  = trp;
    req = 1'b1; wena = we; wbh = w; wbh_fh = fh; addr = a; wdata = d;
    repeat (lat) @(posedge clock);
    #1;
    req = 1'b0;
    if (we && !trp) ref_mem[wi] = nw;
    @(posedge clock); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2048; i++) begin
      ram[i]     = '0;
      ref_mem[i] = '0;
    end
    reset = 1'b1; req = 1'b0; wena = 1'b0; wbh = WBH_WORD; wbh_fh = 1'b0;
    addr = '0; wdata = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock); #1;

    // Word store and load
    do_req(1'b1, WBH_WORD, 1'b0, 13'h010, 32'hDEAD_BEEF);
    check("lit_word_st_data", last_wdata, 32'hDEAD_BEEF);
    check("lit_word_st_addr", last_waddr, 32'h4);
    do_req(1'b0, WBH_WORD, 1'b0, 13'h010, 32'h0);
    check("lit_word_ld", last_rdata, 32'hDEAD_BEEF);

    // Sub-word read-modify-write
    poke(4, 32'h1122_3344);
    do_req(1'b1, WBH_BYTE, 1'b0, 13'h012, 32'h0000_00AA);
    check("lit_byte_rmw", last_wdata, 32'h11AA_3344);
    poke(4, 32'h1122_3344);
    do_req(1'b1, WBH_HALF, 1'b0, 13'h012, 32'h0000_BEEF);
    check("lit_half_rmw", last_wdata, 32'hBEEF_3344);

    // Load extension
    poke(5, 32'h80F0_7F01);
    do_req(1'b0, WBH_BYTE, 1'b1, 13'h015, 32'h0);
    check("lit_lb_15", last_rdata, 32'h0000_007F);
    do_req(1'b0, WBH_BYTE, 1'b1, 13'h016, 32'h0);
    check("lit_lb_16", last_rdata, 32'hFFFF_FFF0);
    do_req(1'b0, WBH_BYTE, 1'b0, 13'h016, 32'h0);
    check("lit_lbu_16", last_rdata, 32'h0000_00F0);
    do_req(1'b0, WBH_HALF, 1'b1, 13'h016, 32'h0);
    check("lit_lh_16", last_rdata, 32'hFFFF_80F0);
    do_req(1'b0, WBH_HALF, 1'b0, 13'h016, 32'h0);
    check("lit_lhu_16", last_rdata, 32'h0000_80F0);
    do_req(1'b0, WBH_BYTE, 1'b1, 13'h017, 32'h0);
    check("lit_lb_17", last_rdata, 32'hFFFF_FF80);
    do_req(1'b0, WBH_BYTE, 1'b1, 13'h014, 32'h0);
    check("lit_lb_14", last_rdata, 32'h0000_0001);
    do_req(1'b0, 2'b11, 1'b1, 13'h014, 32'h0);
    check("lit_lw_wbh11", last_rdata, 32'h80F0_7F01);

    // Reset while a byte store sits in RD; the held request is then re-accepted
    poke(4, 32'h1122_3344);
    acc_cyc = -1; exp_ready = -1; exp_wena = -1; pend_load = 1'b0; exp_mis = 1'b0;
    req = 1'b1; wena = 1'b1; wbh = WBH_BYTE; wbh_fh = 1'b0; addr = 13'h011; wdata = 32'h55;
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_ram_hold", ram[4], 32'h1122_3344);
    do_req(1'b1, WBH_BYTE, 1'b0, 13'h011, 32'h0000_0055);
    check("lit_rst_reaccept", last_wdata, 32'h1122_5544);

    // Misaligned half store
    last_wdata = '0;
    do_req(1'b1, WBH_HALF, 1'b0, 13'h013, 32'h0000_CAFE);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("lit_trap_flag", last_mis, 32'h1);
    check("lit_trap_ram", ram[4], 32'h1122_5544);
`else
    check("lit_align_half", last_wdata, 32'hCAFE_5544);
`endif

    check("ram_w4", ram[4], ref_mem[4]);
    check("ram_w5", ram[5], ref_mem[5]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
